gcd_dispatch: RTL and testbench
===============================

# gcd_dispatch

Job dispatcher upstream of the subtractive GCD engine (controller plus datapath). It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. It restarts the engine for each pair, holds the operands stable while the engine runs, captures the result when the engine signals done, and presents it on a valid/ready output stream. Zero operands, which would stall a subtractive engine forever, are resolved locally without starting the engine.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits
- DEPTH, 4, input FIFO entries; power of two, ≥2

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  operand pair offered
- in_ready  out  1  FIFO can accept a pair
- in_x  in  WIDTH  operand x
- in_y  in  WIDTH  operand y
- eng_rst  out  1  engine restart; engine samples eng_x/eng_y on it
- eng_x  out  WIDTH  operand x to engine
- eng_y  out  WIDTH  operand y to engine
- eng_done  in  1  engine finished; level, held until next eng_rst
- eng_gcd  in  WIDTH  engine result, valid while eng_done=1
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_gcd  out  WIDTH  result
- out_x, out_y  out  WIDTH  original operands echoed with the result
- out_err  out  1  result invalid (watchdog expiry only)
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- FIFO: push on in_valid&&in_ready.
  - in_ready = !full, registered from count; a pop in the same cycle does not free a slot for a push.
  - Pop occurs on the cycle the FSM leaves IDLE.
  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into operand registers (opx, opy).
    - If opx==0 or opy==0 → OUT with out_gcd = opx|opy (gcd(0,0)=0, out_err=0).
    - Else → KICK.
  - KICK: eng_rst=1 for exactly one cycle; eng_x/eng_y=opx/opy → RUN.
  - RUN: eng_rst=0, operands held. On eng_done=1, capture eng_gcd into out_gcd → OUT.
  - OUT: out_valid=1, out_gcd/out_x/out_y/out_err stable. On out_ready=1 → IDLE, out_valid drops next cycle.
- eng_done is ignored outside RUN; a stale done from a previous job cannot complete the current one because KICK precedes RUN.
- All outputs registered. busy = (count!=0) || (state!=IDLE).
- Reset values:
  - state IDLE; FIFO empty; in_ready=1 (first cycle after reset)
  - eng_rst=1 while reset is high, then 0
  - eng_x=eng_y=0
  - out_valid=0, out_gcd=out_x=out_y=0, out_err=0, busy=0
- Reset mid-operation (any state): FIFO contents and the in-flight job are discarded, no result is emitted, and the engine is held in reset.

## Timing
- Push at edge N into an empty FIFO with FSM in IDLE: pop at edge N+1, eng_rst high during cycle N+1..N+2 (one cycle), RUN from edge N+2.
- Engine path: out_valid rises one cycle after the first RUN cycle that sees eng_done=1.
- Bypass path (zero operand): out_valid high two cycles after the accepting push.
- Result handshake completes on out_valid&&out_ready. The next job can be popped the cycle after, so back-to-back jobs have a minimum 1 cycle of IDLE between them.
- Full FIFO with out_ready low: in_ready=0 and in_valid is ignored; no data is lost or overwritten.
- Simultaneous push and pop when not full: both take effect and count is unchanged.

## Configuration
- GCD_WATCHDOG_EN:
  - Defined: adds parameter WDOG_CYCLES (default 1024) and a RUN-state cycle counter, cleared in KICK. If it reaches WDOG_CYCLES without eng_done, → OUT with out_gcd=0 and out_err=1; the engine is re-kicked for the next job as normal.
  - Undefined: no counter, RUN waits indefinitely, out_err tied to 0.

## Test plan
- Push (12,18), out_ready=1, model engine returns 6 after 20 cycles → eng_x=12, eng_y=18, one-cycle eng_rst pulse; out_gcd=6, out_x=12, out_y=18, out_err=0.
- Push (0,7), then (0,0) → out_gcd=7, then 0; eng_rst never pulses; each out_valid two cycles after its push.
- out_ready=0, push 5 pairs back-to-back → 4 accepted, in_ready=0 after the 4th; release out_ready → 4 results in FIFO order; then the 5th pair is accepted once re-offered.
- Result (9,27)→9 held with out_ready=0 for 10 cycles → out_valid and out_gcd=9 stable throughout; exactly one transfer.
- Assert reset during RUN of (35,21), with 2 jobs queued → no out_valid, busy=0, in_ready=1 after reset; a fresh (35,21) job → 7.
- GCD_WATCHDOG_EN, WDOG_CYCLES=16, engine never asserts done → out_gcd=0, out_err=1 after 16 RUN cycles; the next job (4,6) → 2, out_err=0.

Source files
------------

// File: rtl/gcd_dispatch.sv
// Job dispatcher for a subtractive GCD engine: FIFO-buffered operand pairs, engine kick/run/capture FSM.
// Optional RUN-state watchdog enabled by defining GCD_WATCHDOG_EN.
module gcd_dispatch #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
`ifdef GCD_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES = 1024
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             eng_rst,
    output logic [WIDTH-1:0] eng_x,
    output logic [WIDTH-1:0] eng_y,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_gcd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic             out_err,
    output logic             busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        KICK,
        RUN,
        OUT
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WIDTH-1:0] r_memX [DEPTH];
    logic [WIDTH-1:0] r_memY [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_countNext;
    logic             r_inReady;

    logic [WIDTH-1:0] r_opX;
    logic [WIDTH-1:0] r_opY;
    logic [WIDTH-1:0] r_outGcd;
    logic             r_outValid;
    logic             r_engRst;
    logic             r_busy;

    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_headX;
    logic [WIDTH-1:0] w_headY;
    logic             w_bypass;
    logic             w_wdogExpire;

    assign w_push   = in_valid && r_inReady;
    assign w_headX  = r_memX[r_rdPtr];
    assign w_headY  = r_memY[r_rdPtr];
    assign w_bypass = (w_headX == '0) || (w_headY == '0);

    assign in_ready  = r_inReady;
    assign eng_rst   = r_engRst;
    assign eng_x     = r_opX;
    assign eng_y     = r_opY;
    assign out_valid = r_outValid;
    assign out_gcd   = r_outGcd;
    assign out_x     = r_opX;
    assign out_y     = r_opY;
    assign busy      = r_busy;

`ifdef GCD_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] r_wdog;
    logic          r_outErr;

    assign w_wdogExpire = (r_state == RUN) && (r_wdog == WW'(WDOG_CYCLES - 1));
    assign out_err      = r_outErr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog   <= '0;
            r_outErr <= 1'b0;
        end else begin
            if (r_state == KICK) begin
                r_wdog <= '0;
            end else if ((r_state == RUN) && !w_wdogExpire) begin
                r_wdog <= r_wdog + WW'(1);
            end
            if (w_pop || ((r_state == RUN) && eng_done)) begin
                r_outErr <= 1'b0;
            end else if (w_wdogExpire) begin
                r_outErr <= 1'b1;
            end
        end
    end
`else
    assign w_wdogExpire = 1'b0;
    assign out_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Zero operands never reach the engine; they resolve straight to OUT.
    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_nextState = w_bypass ? OUT : KICK;
                end
            end
            KICK: w_nextState = RUN;
            RUN: begin
                if (eng_done || w_wdogExpire) begin
                    w_nextState = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_countNext = r_count;
        case ({w_push, w_pop})
            2'b10:   w_countNext = r_count + CW'(1);
            2'b01:   w_countNext = r_count - CW'(1);
            default: w_countNext = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memX[r_wrPtr] <= in_x;
            r_memY[r_wrPtr] <= in_y;
        end
    end

    // in_ready follows the current count, so a same-cycle pop never frees a slot early.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_inReady  <= 1'b1;
            r_opX      <= '0;
            r_opY      <= '0;
            r_outGcd   <= '0;
            r_outValid <= 1'b0;
            r_engRst   <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PW'(1);
                r_opX   <= w_headX;
                r_opY   <= w_headY;
                if (w_bypass) begin
                    r_outGcd <= w_headX | w_headY;
                end
            end
            if ((r_state == RUN) && eng_done) begin
                r_outGcd <= eng_gcd;
            end else if (w_wdogExpire) begin
                r_outGcd <= '0;
            end
            r_count    <= w_countNext;
            r_inReady  <= (w_countNext != FULL_CNT);
            r_outValid <= (w_nextState == OUT);
            r_engRst   <= (w_nextState == KICK);
            r_busy     <= (w_countNext != '0) || (w_nextState != IDLE);
        end
    end

endmodule

// File: tb/tb_gcd_dispatch.sv
// Self-checking bench for gcd_dispatch: behavioural engine model, scoreboard queue, table vectors plus corner sequences.
// Watchdog sequence runs only when GCD_WATCHDOG_EN is defined.
module tb_gcd_dispatch;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_x = '0;
    logic [7:0] in_y = '0;
    logic       eng_rst;
    logic [7:0] eng_x;
    logic [7:0] eng_y;
    logic       eng_done = 1'b0;
    logic [7:0] eng_gcd = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_gcd;
    logic [7:0] out_x;
    logic [7:0] out_y;
    logic       out_err;
    logic       busy;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] g;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] g;
    } vec_t;

    exp_t sbQ[$];
    int   nCompared = 0;
    int   nMismatched = 0;

    int   engLatency = 20;
    bit   engHang = 1'b0;
    int   engCnt = 0;
    int   engRstCycles = 0;
    logic [7:0] kickX = '0;
    logic [7:0] kickY = '0;

    always #5 clk = ~clk;

`ifdef GCD_WATCHDOG_EN
    gcd_dispatch #(.WIDTH(8), .DEPTH(4), .WDOG_CYCLES(16)) dut (
`else
    gcd_dispatch #(.WIDTH(8), .DEPTH(4)) dut (
`endif
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .eng_rst(eng_rst), .eng_x(eng_x), .eng_y(eng_y),
        .eng_done(eng_done), .eng_gcd(eng_gcd),
        .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
        .out_x(out_x), .out_y(out_y), .out_err(out_err), .busy(busy)
    );

    function automatic logic [7:0] refGcd(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, q, t;
        p = a;
        q = b;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    // Engine model: samples operands while eng_rst is high, raises done after engLatency cycles.
    always @(posedge clk) begin
        if (eng_rst) begin
            eng_done <= 1'b0;
            engCnt   <= engLatency;
            eng_gcd  <= refGcd(eng_x, eng_y);
        end else if (!eng_done && !engHang) begin
            if (engCnt <= 1) eng_done <= 1'b1;
            else engCnt <= engCnt - 1;
        end
    end

    always @(negedge clk) begin
        if (eng_rst) begin
            engRstCycles <= engRstCycles + 1;
            kickX <= eng_x;
            kickY <= eng_y;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic [7:0] g,
                                 input logic err, input int maxWait, output bit accepted);
        exp_t e;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        for (int i = 0; i < maxWait && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                e.x = x; e.y = y; e.g = g; e.err = err;
                sbQ.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic collectResult(input int maxWait);
        exp_t e;
        bit got = 1'b0;
        for (int i = 0; i < maxWait && !got; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got = 1'b1;
                checkOutput("sb_nonempty", 32'(sbQ.size() != 0), 1);
                if (sbQ.size() != 0) begin
                    e = sbQ.pop_front();
                    checkOutput("out_gcd", 32'(out_gcd), 32'(e.g));
                    checkOutput("out_x", 32'(out_x), 32'(e.x));
                    checkOutput("out_y", 32'(out_y), 32'(e.y));
                    checkOutput("out_err", 32'(out_err), 32'(e.err));
                end
            end
            @(posedge clk);
            #1;
        end
        checkOutput("result_seen", 32'(got), 1);
    endtask

    task automatic waitOutValid(input int maxWait, output int n);
        n = 0;
        while (!out_valid && n < maxWait) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    vec_t vecs[8];
    vec_t fill[5];
    bit   acc;
    int   n;
    int   accCount;
    int   rstBefore;
    bit   stable;
    bit   sawValid;

    initial begin
        vecs[0] = '{8'd48,  8'd36,  8'd12};
        vecs[1] = '{8'd17,  8'd5,   8'd1};
        vecs[2] = '{8'd0,   8'd7,   8'd7};
        vecs[3] = '{8'd0,   8'd0,   8'd0};
        vecs[4] = '{8'd100, 8'd75,  8'd25};
        vecs[5] = '{8'd255, 8'd255, 8'd255};
        vecs[6] = '{8'd7,   8'd0,   8'd7};
        vecs[7] = '{8'd128, 8'd96,  8'd32};
        fill[0] = '{8'd8,  8'd12, 8'd4};
        fill[1] = '{8'd0,  8'd9,  8'd9};
        fill[2] = '{8'd21, 8'd14, 8'd7};
        fill[3] = '{8'd5,  8'd5,  8'd5};
        fill[4] = '{8'd60, 8'd45, 8'd15};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_eng_rst_high", 32'(eng_rst), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        checkOutput("rst_eng_rst_low", 32'(eng_rst), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_eng_x", 32'(eng_x), 0);
        checkOutput("rst_out_gcd", 32'(out_gcd), 0);

        // (12,18) through the engine with 20-cycle latency
        out_ready = 1'b1;
        engLatency = 20;
        rstBefore = engRstCycles;
        applyStimulus(8'd12, 8'd18, 8'd6, 1'b0, 10, acc);
        checkOutput("t1_accept", 32'(acc), 1);
        waitOutValid(100, n);
        checkOutput("t1_latency", 32'(n), 23);
        collectResult(20);
        checkOutput("t1_kick_cycles", 32'(engRstCycles - rstBefore), 1);
        checkOutput("t1_kick_x", 32'(kickX), 12);
        checkOutput("t1_kick_y", 32'(kickY), 18);

        // Zero-operand bypass: (0,7) then (0,0)
        rstBefore = engRstCycles;
        out_ready = 1'b0;
        applyStimulus(8'd0, 8'd7, 8'd7, 1'b0, 10, acc);
        checkOutput("byp1_early", 32'(out_valid), 0);
        @(posedge clk); #1;
        checkOutput("byp1_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        collectResult(5);
        out_ready = 1'b0;
        applyStimulus(8'd0, 8'd0, 8'd0, 1'b0, 10, acc);
        checkOutput("byp2_early", 32'(out_valid), 0);
        @(posedge clk); #1;
        checkOutput("byp2_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        collectResult(5);
        checkOutput("byp_no_kick", 32'(engRstCycles - rstBefore), 0);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            engLatency = int'($urandom_range(1, 8));
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].g, 1'b0, 20, acc);
            checkOutput("tbl_accept", 32'(acc), 1);
            collectResult(100);
        end

        // Full FIFO behind a held result: 4 accepted, 5th refused
        engLatency = 3;
        out_ready = 1'b0;
        applyStimulus(8'd20, 8'd30, 8'd10, 1'b0, 10, acc);
        waitOutValid(50, n);
        checkOutput("full_prime_valid", 32'(out_valid), 1);
        accCount = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(fill[i].x, fill[i].y, fill[i].g, 1'b0, 1, acc);
            accCount += int'(acc);
        end
        checkOutput("full_accepted", 32'(accCount), 4);
        checkOutput("full_in_ready", 32'(in_ready), 0);
        checkOutput("full_fifth_refused", 32'(acc), 0);
        checkOutput("full_busy", 32'(busy), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) collectResult(50);
        applyStimulus(fill[4].x, fill[4].y, fill[4].g, 1'b0, 10, acc);
        checkOutput("full_fifth_reoffer", 32'(acc), 1);
        collectResult(50);

        // Result held under back-pressure for 10 cycles
        out_ready = 1'b0;
        applyStimulus(8'd9, 8'd27, 8'd9, 1'b0, 10, acc);
        waitOutValid(50, n);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid || out_gcd != 8'd9) stable = 1'b0;
        end
        @(posedge clk); #1;
        checkOutput("hold_stable", 32'(stable), 1);
        out_ready = 1'b1;
        collectResult(5);
        checkOutput("hold_single_xfer", 32'(out_valid), 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_no_repeat", 32'(out_valid), 0);

        // Reset during RUN with two jobs queued
        engLatency = 50;
        applyStimulus(8'd35, 8'd21, 8'd7, 1'b0, 10, acc);
        applyStimulus(8'd1, 8'd2, 8'd1, 1'b0, 10, acc);
        applyStimulus(8'd3, 8'd4, 8'd1, 1'b0, 10, acc);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_eng_rst", 32'(eng_rst), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        sbQ.delete();
        @(posedge clk); #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 0);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_in_ready", 32'(in_ready), 1);
        sawValid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        @(posedge clk); #1;
        checkOutput("midrst_no_result", 32'(sawValid), 0);
        engLatency = 5;
        applyStimulus(8'd35, 8'd21, 8'd7, 1'b0, 10, acc);
        collectResult(50);

`ifdef GCD_WATCHDOG_EN
        // Engine never finishes: watchdog expires after 16 RUN cycles
        engHang = 1'b1;
        applyStimulus(8'd10, 8'd15, 8'd0, 1'b1, 10, acc);
        waitOutValid(100, n);
        checkOutput("wdog_latency", 32'(n), 18);
        collectResult(5);
        engHang = 1'b0;
        engLatency = 4;
        applyStimulus(8'd4, 8'd6, 8'd2, 1'b0, 10, acc);
        collectResult(50);
`endif

        checkOutput("sb_drained", 32'(sbQ.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
